iic_target_rx: RTL and testbench

I2C target-side (responder) receiver for the same bus the master SCL generator drives. It oversamples SCL/SDA on the system clock and detects START, STOP and repeated START. It matches a fixed 7-bit address, ACKs write transfers and delivers each received data byte on a one-cycle strobe. It sits behind the open-drain pad logic and feeds a byte consumer such as a local register file or a display model in the LCD loopback bench.

---
 rtl/iic_pkg.sv | 19 +
 rtl/iic_line_sync.sv | 53 +++++
 rtl/iic_target_rx.sv | 177 +++++++++++++++++
 tb/tb_iic_target_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C target definitions: receiver FSM states and bus-level constants.
package iic_pkg;

    localparam logic        IIC_ACK    = 1'b0;
    localparam logic        IIC_NACK   = 1'b1;
    localparam int unsigned IIC_BITS   = 8;
    localparam int unsigned IIC_ADDR_W = 7;
    localparam int unsigned IIC_CNT_W  = $clog2(IIC_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_WAIT_STOP
    } iic_rx_state_t;

endpackage

// File: rtl/iic_line_sync.sv
// Pin synchronizer with rise/fall strobes for one I2C line.
// Defining IIC_TARGET_FILTER_EN adds a 3-sample stability filter after the synchronizer.
module iic_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic lvl_c,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
`ifdef IIC_TARGET_FILTER_EN
    logic [1:0] hist_q, hist_d;
`endif

    always_comb begin
        meta_d = i_pin;
        sync_d = meta_q;
`ifdef IIC_TARGET_FILTER_EN
        hist_d = {hist_q[0], sync_q};
        // Level moves only once three consecutive synchronized samples agree
        lvl_c  = (sync_q == hist_q[0] && sync_q == hist_q[1]) ? sync_q : prev_q;
`else
        lvl_c  = sync_q;
`endif
        prev_d = lvl_c;
        rise_c = lvl_c & ~prev_q;
        fall_c = ~lvl_c & prev_q;
    end

    // Idle bus is high, so every stage resets to 1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
`ifdef IIC_TARGET_FILTER_EN
            hist_q <= 2'b11;
`endif
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
`ifdef IIC_TARGET_FILTER_EN
            hist_q <= hist_d;
`endif
        end
    end

endmodule

// File: rtl/iic_target_rx.sv
// Write-only I2C target receiver: START/STOP detection, address match, ACK and byte delivery.
// Optional glitch filter on both lines via IIC_TARGET_FILTER_EN (see iic_line_sync).
module iic_target_rx
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] ADDR = 7'h27
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_scl,
    input  logic                i_sda,
    output logic                o_sda_oe,
    output logic [IIC_BITS-1:0] o_data,
    output logic                o_data_valid,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_addr_match,
    output logic                o_busy
);

    // Output-enable value that puts the given bit level on the open-drain line
    localparam logic ACK_OE  = (IIC_ACK == 1'b0);
    localparam logic NACK_OE = (IIC_NACK == 1'b0);

    logic scl_lvl_c, scl_rise_c, scl_fall_c;
    logic sda_lvl_c, sda_rise_c, sda_fall_c;
    logic start_c, stop_c;
    logic [IIC_BITS-1:0] shift_next_c;

    iic_rx_state_t       state_q, state_d;
    logic [IIC_CNT_W-1:0] cnt_q, cnt_d;
    logic                full_q, full_d;
    logic [IIC_BITS-1:0] shift_q, shift_d;
    logic [IIC_BITS-1:0] data_q, data_d;
    logic                sda_oe_q, sda_oe_d;
    logic                dv_q, dv_d;
    logic                start_q, start_d;
    logic                stop_q, stop_d;
    logic                match_q, match_d;
    logic                busy_q, busy_d;
    logic                scl_rise_q, scl_rise_d;
    logic                scl_fall_q, scl_fall_d;

    iic_line_sync u_scl_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_scl),
        .lvl_c  (scl_lvl_c),
        .rise_c (scl_rise_c),
        .fall_c (scl_fall_c)
    );

    iic_line_sync u_sda_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_sda),
        .lvl_c  (sda_lvl_c),
        .rise_c (sda_rise_c),
        .fall_c (sda_fall_c)
    );

    always_comb begin
        start_c      = sda_fall_c & scl_lvl_c;
        stop_c       = sda_rise_c & scl_lvl_c;
        shift_next_c = {shift_q[IIC_BITS-2:0], sda_lvl_c};

        state_d    = state_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        shift_d    = shift_q;
        data_d     = data_q;
        sda_oe_d   = sda_oe_q;
        dv_d       = 1'b0;
        start_d    = start_c;
        stop_d     = stop_c;
        match_d    = match_q;
        busy_d     = busy_q;
        scl_rise_d = scl_rise_c;
        scl_fall_d = scl_fall_c;

        if (stop_c) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = NACK_OE;
            match_d  = 1'b0;
            busy_d   = 1'b0;
        end else if (start_c) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = NACK_OE;
            match_d  = 1'b0;
            busy_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise_q && !full_q) begin
                        shift_d = shift_next_c;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == IIC_CNT_W'(IIC_BITS - 1)) begin
                            full_d = 1'b1;
                            if (state_q == ST_DATA) begin
                                data_d = shift_next_c;
                                dv_d   = 1'b1;
                            end
                        end
                    end else if (scl_fall_q && full_q) begin
                        // 8th SCL fall: decide ACK/NACK for the 9th clock
                        full_d = 1'b0;
                        if (state_q == ST_DATA) begin
                            sda_oe_d = ACK_OE;
                            state_d  = ST_DATA_ACK;
                        end else if (shift_q[IIC_BITS-1:1] == ADDR && shift_q[0] == 1'b0) begin
                            sda_oe_d = ACK_OE;
                            match_d  = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d = NACK_OE;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe_d = NACK_OE;
                        cnt_d    = '0;
                        state_d  = ST_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            sda_oe_q   <= 1'b0;
            dv_q       <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            sda_oe_q   <= sda_oe_d;
            dv_q       <= dv_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            match_q    <= match_d;
            busy_q     <= busy_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
        end
    end

    assign o_sda_oe     = sda_oe_q;
    assign o_data       = data_q;
    assign o_data_valid = dv_q;
    assign o_start      = start_q;
    assign o_stop       = stop_q;
    assign o_addr_match = match_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_iic_target_rx.sv
// Self-checking bench for iic_target_rx: transaction table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_iic_target_rx;

    localparam int HP = 10;
`ifdef IIC_TARGET_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       sda_line;
    logic       o_sda_oe, o_data_valid, o_start, o_stop, o_addr_match, o_busy;
    logic [7:0] o_data;

    assign sda_line = m_sda & ~o_sda_oe;

    always #5 clk = ~clk;

    iic_target_rx #(.ADDR(7'h27)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_scl        (m_scl),
        .i_sda        (sda_line),
        .o_sda_oe     (o_sda_oe),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_start      (o_start),
        .o_stop       (o_stop),
        .o_addr_match (o_addr_match),
        .o_busy       (o_busy)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         start_cnt = 0, stop_cnt = 0, dv_cnt = 0;
    logic [7:0] rx [0:63];
    logic       oe_seen = 1'b0;

    always @(negedge clk) begin
        if (o_start) start_cnt++;
        if (o_stop) stop_cnt++;
        if (o_data_valid) begin
            rx[dv_cnt % 64] = o_data;
            dv_cnt++;
        end
        if (o_sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        tick(2); m_sda = 1'b1;
        tick(HP); m_scl = 1'b1;
        tick(HP); m_sda = 1'b0;
        tick(HP); m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(2); m_sda = 1'b0;
        tick(HP); m_scl = 1'b1;
        tick(HP); m_sda = 1'b1;
        tick(HP);
    endtask

    task automatic send_bit(input logic b);
        tick(2); m_sda = b;
        tick(HP); m_scl = 1'b1;
        tick(HP); m_scl = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) send_bit(b[k]);
    endtask

    task automatic ack_bit(output logic acked, output logic match);
        tick(2); m_sda = 1'b1;
        tick(HP); m_scl = 1'b1;
        tick(HP / 2);
        acked = ~sda_line;
        match = o_addr_match;
        tick(HP / 2); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic match);
        send8(b);
        ack_bit(acked, match);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_dv;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic ack, match;
        int   s0, p0, v0;

        vecs[0] = '{7'h27, 1'b0, 2, 8'hA5, 8'h3C, 1'b1, 2};
        vecs[1] = '{7'h28, 1'b0, 2, 8'h11, 8'h22, 1'b0, 0};
        vecs[2] = '{7'h27, 1'b1, 0, 8'h00, 8'h00, 1'b0, 0};
        vecs[3] = '{7'h27, 1'b0, 1, 8'h00, 8'h00, 1'b1, 1};
        vecs[4] = '{7'h27, 1'b0, 1, 8'hFF, 8'h00, 1'b1, 1};
        vecs[5] = '{7'h26, 1'b0, 1, 8'h55, 8'h00, 1'b0, 0};
        vecs[6] = '{7'h67, 1'b0, 1, 8'h99, 8'h00, 1'b0, 0};

        // Reset values
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        tick(3);
        chk("rst_sda_oe", o_sda_oe, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_dv", o_data_valid, 0);
        chk("rst_start", o_start, 0);
        chk("rst_stop", o_stop, 0);
        chk("rst_match", o_addr_match, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;
        tick(5);

        // START and STOP latency on an idle bus
        s0 = start_cnt; p0 = stop_cnt;
        m_sda = 1'b0;
        tick(LAT - 1);
        chk("start_early", o_start, 0);
        chk("busy_early", o_busy, 0);
        tick(1);
        chk("start_lat", o_start, 1);
        chk("busy_rise", o_busy, 1);
        tick(1);
        chk("start_pulse", o_start, 0);
        tick(HP); m_scl = 1'b0;
        tick(HP); m_scl = 1'b1;
        tick(HP); m_sda = 1'b1;
        tick(LAT - 1);
        chk("stop_early", o_stop, 0);
        tick(1);
        chk("stop_lat", o_stop, 1);
        chk("busy_fall", o_busy, 0);
        tick(HP);
        chk("lat_starts", start_cnt - s0, 1);
        chk("lat_stops", stop_cnt - p0, 1);

        // Transaction table
        for (int i = 0; i < 7; i++) begin
            s0 = start_cnt; p0 = stop_cnt; v0 = dv_cnt; oe_seen = 1'b0;
            start_cond();
            send_byte({vecs[i].addr, vecs[i].rw}, ack, match);
            chk($sformatf("v%0d_addr_ack", i), ack, vecs[i].exp_ack);
            chk($sformatf("v%0d_addr_match", i), match, vecs[i].exp_ack);
            for (int b = 0; b < vecs[i].nbytes; b++) begin
                send_byte((b == 0) ? vecs[i].d0 : vecs[i].d1, ack, match);
                chk($sformatf("v%0d_data_ack%0d", i, b), ack, vecs[i].exp_ack);
            end
            stop_cond();
            chk($sformatf("v%0d_starts", i), start_cnt - s0, 1);
            chk($sformatf("v%0d_stops", i), stop_cnt - p0, 1);
            chk($sformatf("v%0d_dv_count", i), dv_cnt - v0, vecs[i].exp_dv);
            chk($sformatf("v%0d_busy_end", i), o_busy, 0);
            chk($sformatf("v%0d_match_end", i), o_addr_match, 0);
            for (int b = 0; b < vecs[i].exp_dv; b++)
                chk($sformatf("v%0d_data%0d", i, b), rx[(v0 + b) % 64], (b == 0) ? vecs[i].d0 : vecs[i].d1);
            if (!vecs[i].exp_ack) chk($sformatf("v%0d_oe_quiet", i), oe_seen, 0);
        end

        // Repeated START after 4 data bits, then address and 0x81
        s0 = start_cnt; v0 = dv_cnt;
        start_cond();
        send_byte({7'h27, 1'b0}, ack, match);
        chk("rs_addr_ack1", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        start_cond();
        chk("rs_match_clear", o_addr_match, 0);
        chk("rs_oe_released", o_sda_oe, 0);
        chk("rs_starts", start_cnt - s0, 2);
        chk("rs_no_partial", dv_cnt - v0, 0);
        send_byte({7'h27, 1'b0}, ack, match);
        chk("rs_addr_ack2", ack, 1);
        send_bit(1'b1);
        for (int k = 0; k < 6; k++) send_bit(1'b0);
        tick(2); m_sda = 1'b1;
        tick(HP); m_scl = 1'b1;
        tick(LAT);
        chk("dv_early", o_data_valid, 0);
        tick(1);
        chk("dv_lat", o_data_valid, 1);
        chk("dv_data", o_data, 8'h81);
        tick(1);
        chk("dv_pulse", o_data_valid, 0);
        tick(HP - LAT - 2); m_scl = 1'b0;
        ack_bit(ack, match);
        chk("rs_data_ack", ack, 1);
        stop_cond();
        chk("rs_dv_count", dv_cnt - v0, 1);
        chk("rs_data", rx[v0 % 64], 8'h81);

        // Reset while the address ACK is being driven
        v0 = dv_cnt;
        start_cond();
        send8({7'h27, 1'b0});
        tick(2); m_sda = 1'b1;
        tick(HP); m_scl = 1'b1;
        tick(HP / 2);
        chk("rst_pre_oe", o_sda_oe, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_oe", o_sda_oe, 0);
        chk("rst_async_match", o_addr_match, 0);
        chk("rst_async_busy", o_busy, 0);
        tick(3);
        rst = 1'b0;
        tick(HP / 2); m_scl = 1'b0;
        send_byte(8'h5A, ack, match);
        chk("post_rst_nack", ack, 0);
        stop_cond();
        chk("post_rst_no_dv", dv_cnt - v0, 0);
        start_cond();
        send_byte({7'h27, 1'b0}, ack, match);
        chk("recover_addr_ack", ack, 1);
        send_byte(8'h42, ack, match);
        chk("recover_data_ack", ack, 1);
        stop_cond();
        chk("recover_dv_count", dv_cnt - v0, 1);
        chk("recover_data", rx[v0 % 64], 8'h42);

        // Short SDA low pulses while SCL is high
        s0 = start_cnt;
        m_sda = 1'b0; tick(2); m_sda = 1'b1; tick(12);
`ifdef IIC_TARGET_FILTER_EN
        chk("glitch2_start", start_cnt - s0, 0);
`else
        chk("glitch2_start", start_cnt - s0, 1);
`endif
        m_sda = 1'b0; tick(3); m_sda = 1'b1; tick(12);
`ifdef IIC_TARGET_FILTER_EN
        chk("glitch3_start", start_cnt - s0, 1);
`else
        chk("glitch3_start", start_cnt - s0, 2);
`endif
        chk("glitch_busy_end", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
